// File: rtl/cpu_pkg.sv
// Shared constants for the CPU writeback path.
//   DATA_W        register data width
//   ADDR_W        register index width
//   NUM_REGS      architectural register count (one busy bit each)
//   WB_FIFO_DEPTH load-result queue depth (power of two)
package cpu_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned NUM_REGS      = 8;
    localparam int unsigned WB_FIFO_DEPTH = 4;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue for the writeback stage.
// Each entry holds {dest, data, killed}. A kill request marks every stored
// entry whose dest matches kill_dest; the pushed entry's killed flag comes
// from the caller so a same-cycle kill can be folded in.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push/push_*       enqueue request and payload (caller guarantees not full)
//   pop               dequeue head (caller guarantees not empty)
//   kill_en/kill_dest dest-match kill of stored entries
//   head_*            head entry contents
//   count             number of stored entries, 0..DEPTH
module wb_fifo #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DEPTH  = cpu_pkg::WB_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_dest,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     push_killed,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [ADDR_W-1:0]        kill_dest,
    output logic [ADDR_W-1:0]        head_dest,
    output logic [DATA_W-1:0]        head_data,
    output logic                     head_killed,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  killed_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign head_dest   = dest_q[rd_ptr];
    assign head_data   = data_q[rd_ptr];
    assign head_killed = killed_q[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Kill flags; the push write comes last so a free slot's stale flag is replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            killed_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill_en && (dest_q[i] == kill_dest)) killed_q[i] <= 1'b1;
            end
            if (push) killed_q[wr_ptr] <= push_killed;
        end
    end

    // Payload storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= push_dest;
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter.
// Merges single-cycle ALU results with queued load results onto one register
// write port. ALU results win the port; loads drain from wb_fifo whenever the
// ALU is not writing. An ALU write to register D kills older queued loads to D
// so a late load cannot overwrite a newer value. busy_mask tracks registers
// with outstanding loads.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/dest/data, alu_ready ALU result handshake
//   mem_valid/dest/data, mem_ready load result handshake
//   issue_valid/issue_dest         load issue notification (sets busy bit)
//   busy_mask                      per-register pending-load flags
//   reg_write_en/dest/data         registered register-file write port
module reg_writeback #(
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = cpu_pkg::WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_dest,
    input  logic [DATA_W-1:0]             alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [ADDR_W-1:0]             mem_dest,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          mem_ready,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_dest,
    output logic [cpu_pkg::NUM_REGS-1:0]  busy_mask,
    output logic                          reg_write_en,
    output logic [ADDR_W-1:0]             reg_write_dest,
    output logic [DATA_W-1:0]             reg_write_data
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 ready_en;
    logic [CNT_W-1:0]     count;
    logic                 not_full_c;
    logic                 alu_acc_c;
    logic                 mem_acc_c;
    logic                 pop_c;
    logic                 live_pop_c;
    logic                 push_killed_c;
    logic [ADDR_W-1:0]    head_dest;
    logic [DATA_W-1:0]    head_data;
    logic                 head_killed;
    logic [NUM_REGS-1:0]  set_mask_c;
    logic [NUM_REGS-1:0]  clr_mask_c;

    // ready_en keeps both handshakes closed until one edge after reset release.
    assign not_full_c = ready_en && (count < CNT_W'(FIFO_DEPTH));
    assign alu_ready  = not_full_c;
    assign mem_ready  = not_full_c;

    // Handshakes, port arbitration and kill of a same-cycle load to the ALU dest.
    always_comb begin
        alu_acc_c     = alu_valid && alu_ready;
        mem_acc_c     = mem_valid && mem_ready;
        pop_c         = !alu_acc_c && (count != '0);
        live_pop_c    = pop_c && !head_killed;
        push_killed_c = alu_acc_c && (alu_dest == mem_dest);
    end

    // Busy-bit set/clear masks; set is applied after clear so it wins.
    always_comb begin
        set_mask_c = '0;
        clr_mask_c = '0;
        if (issue_valid) set_mask_c = NUM_REGS'(1) << issue_dest;
        if (alu_acc_c) begin
            clr_mask_c = NUM_REGS'(1) << alu_dest;
        end else if (live_pop_c) begin
            clr_mask_c = NUM_REGS'(1) << head_dest;
        end
    end

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (mem_acc_c),
        .push_dest   (mem_dest),
        .push_data   (mem_data),
        .push_killed (push_killed_c),
        .pop         (pop_c),
        .kill_en     (alu_acc_c),
        .kill_dest   (alu_dest),
        .head_dest   (head_dest),
        .head_data   (head_data),
        .head_killed (head_killed),
        .count       (count)
    );

    // Registered write port and busy tracking; dest/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en       <= 1'b0;
            busy_mask      <= '0;
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            ready_en  <= 1'b1;
            busy_mask <= (busy_mask & ~clr_mask_c) | set_mask_c;
            if (alu_acc_c) begin
                reg_write_en   <= 1'b1;
                reg_write_dest <= alu_dest;
                reg_write_data <= alu_data;
            end else if (live_pop_c) begin
                reg_write_en   <= 1'b1;
                reg_write_dest <= head_dest;
                reg_write_data <= head_data;
            end else begin
                reg_write_en   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_dest;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic [7:0]  busy_mask;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;

    reg_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .issue_valid    (issue_valid),
        .issue_dest     (issue_dest),
        .busy_mask      (busy_mask),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
        logic        killed;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    logic        m_rdy = 1'b0;
    logic [7:0]  m_busy = '0;
    logic        m_en = 1'b0;
    logic [2:0]  m_dest = '0;
    logic [15:0] m_data = '0;
    logic        m_alu_acc = 1'b0;
    logic        m_mem_acc = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic       room;
        logic [7:0] clr;
        ent_t       e;
        clr = '0;
        if (rst) begin
            q.delete();
            m_busy = '0; m_en = 1'b0; m_dest = '0; m_data = '0;
            m_rdy = 1'b0; m_alu_acc = 1'b0; m_mem_acc = 1'b0;
        end else begin
            room      = m_rdy && (q.size() < DEPTH);
            m_alu_acc = alu_valid && room;
            m_mem_acc = mem_valid && room;
            if (m_alu_acc) begin
                foreach (q[i]) if (q[i].dest == alu_dest) q[i].killed = 1'b1;
                m_en = 1'b1; m_dest = alu_dest; m_data = alu_data;
                clr[alu_dest] = 1'b1;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (!e.killed) begin
                    m_en = 1'b1; m_dest = e.dest; m_data = e.data;
                    clr[e.dest] = 1'b1;
                end else begin
                    m_en = 1'b0;
                end
            end else begin
                m_en = 1'b0;
            end
            if (m_mem_acc)
                q.push_back('{dest: mem_dest, data: mem_data,
                              killed: m_alu_acc && (alu_dest == mem_dest)});
            m_busy = m_busy & ~clr;
            if (issue_valid) m_busy[issue_dest] = 1'b1;
            m_rdy = 1'b1;
        end
    endtask

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = m_rdy && (q.size() < DEPTH);
        chk("write_en",   32'(reg_write_en),   32'(m_en));
        chk("write_dest", 32'(reg_write_dest), 32'(m_dest));
        chk("write_data", 32'(reg_write_data), 32'(m_data));
        chk("busy_mask",  32'(busy_mask),      32'(m_busy));
        chk("alu_ready",  32'(alu_ready),      32'(exp_rdy));
        chk("mem_ready",  32'(mem_ready),      32'(exp_rdy));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        issue_valid = 1'b0; issue_dest = '0;
    endtask

    initial begin
        int na, nm, low, writes;

        // Reset: handshakes stay closed until one edge after release
        rst = 1'b1;
        idle();
        tick();
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_write_en",  32'(reg_write_en), 32'd0);
        chk("rst_busy",      32'(busy_mask), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(mem_ready), 32'd1);

        // ALU only
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h00A5;
        tick();
        alu_valid = 1'b0;
        chk("alu_en",   32'(reg_write_en), 32'd1);
        chk("alu_dest", 32'(reg_write_dest), 32'd3);
        chk("alu_data", 32'(reg_write_data), 32'h00A5);
        tick();
        chk("alu_en_after", 32'(reg_write_en), 32'd0);

        // Load with idle ALU: two-cycle latency
        issue_valid = 1'b1; issue_dest = 3'd5;
        tick();
        issue_valid = 1'b0;
        chk("issue_busy5", 32'(busy_mask[5]), 32'd1);
        mem_valid = 1'b1; mem_dest = 3'd5; mem_data = 16'h1234;
        tick();
        mem_valid = 1'b0;
        chk("load_not_yet", 32'(reg_write_en), 32'd0);
        tick();
        chk("load_en",    32'(reg_write_en), 32'd1);
        chk("load_dest",  32'(reg_write_dest), 32'd5);
        chk("load_data",  32'(reg_write_data), 32'h1234);
        chk("load_busy5", 32'(busy_mask[5]), 32'd0);

        // Contention: six ALU results against four loads
        na = 0; nm = 0; low = 0; writes = 0;
        for (int c = 0; c < 20; c++) begin
            alu_valid = (na < 6); alu_dest = 3'(na % 2); alu_data = 16'(16'h0100 + na);
            mem_valid = (nm < 4); mem_dest = 3'(4 + nm);  mem_data = 16'(16'h0200 + nm);
            if (alu_valid && !alu_ready) low++;
            tick();
            if (m_alu_acc) na++;
            if (m_mem_acc) nm++;
            if (reg_write_en) writes++;
        end
        idle();
        chk("contend_stall_cycles", 32'(low), 32'd1);
        chk("contend_writes",       32'(writes), 32'd10);
        chk("contend_alu_acc",      32'(na), 32'd6);
        chk("contend_mem_acc",      32'(nm), 32'd4);

        // Kill: newer ALU write to the same register suppresses the queued load
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hBEEF;
        tick();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h0001;
        tick();
        alu_valid = 1'b0;
        chk("kill_alu_en",   32'(reg_write_en), 32'd1);
        chk("kill_alu_data", 32'(reg_write_data), 32'h0001);
        tick();
        chk("kill_pop_en",   32'(reg_write_en), 32'd0);
        chk("kill_hold_data", 32'(reg_write_data), 32'h0001);

        // Reset mid-operation with three loads queued
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_dest = 3'(k + 1);
            mem_valid = 1'b1; mem_dest = 3'(k + 4); mem_data = 16'(16'hC000 + k);
            alu_valid = 1'b1; alu_dest = 3'd7; alu_data = 16'(16'hA000 + k);
            tick();
        end
        idle();
        chk("pre_rst_busy", 32'(busy_mask), 32'h0E);
        chk("pre_rst_qlen", 32'(q.size()), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_mask), 32'd0);
        chk("mid_rst_en",   32'(reg_write_en), 32'd0);
        writes = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (reg_write_en) writes++;
        end
        chk("post_rst_writes", 32'(writes), 32'd0);
        chk("post_rst_empty",  32'(mem_ready), 32'd1);

        // Randomized traffic; a refused load is held until accepted
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            alu_valid = $urandom_range(0, 1) == 1;
            alu_dest  = 3'($urandom_range(0, 7));
            alu_data  = 16'($urandom);
            if (!(mem_valid && !m_mem_acc)) begin
                mem_valid = $urandom_range(0, 1) == 1;
                mem_dest  = 3'($urandom_range(0, 7));
                mem_data  = 16'($urandom);
            end
            issue_valid = $urandom_range(0, 2) == 0;
            issue_dest  = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The parameters SHALL be:
  - DATA_W, 16, register data width.
  - ADDR_W, 3, register index width.
  - FIFO_DEPTH, 4, load-result queue depth; power of two.
REQ-002 The ports SHALL be:
  - clk  in  1  single clock, rising edge.
  - rst  in  1  synchronous, active-high reset.
  - alu_valid  in  1  ALU result present.
  - alu_dest  in  ADDR_W  ALU destination register.
  - alu_data  in  DATA_W  ALU result.
  - alu_ready  out  1  ALU result accepted this cycle.
  - mem_valid  in  1  load result present.
  - mem_dest  in  ADDR_W  load destination register.
  - mem_data  in  DATA_W  load data.
  - mem_ready  out  1  queue can accept a load.
  - issue_valid  in  1  load issued this cycle.
  - issue_dest  in  ADDR_W  destination of the issued load.
  - busy_mask  out  8  per-register pending-load flags.
  - reg_write_en  out  1  write strobe to the register file.
  - reg_write_dest  out  ADDR_W  write index.
  - reg_write_data  out  DATA_W  write data.
REQ-003 The block SHALL be clocked by one clock, with synchronous, active-high reset, using the port names clk and rst.

Function
REQ-004 Accept rules:
  - An ALU result SHALL be accepted when alu_valid=1 and alu_ready=1.
  - A load SHALL be accepted when mem_valid=1 and mem_ready=1.
REQ-005 alu_ready SHALL be 0 only when the queue is full; otherwise it SHALL be 1.
REQ-006 mem_ready SHALL equal (count < FIFO_DEPTH), evaluated on the registered count; there is no same-cycle pop bypass.
REQ-007 An accepted ALU result SHALL appear on reg_write_en/dest/data exactly 1 cycle after acceptance.
REQ-008 In each cycle with no ALU accept and a non-empty queue, the head entry SHALL be popped. If the entry is live, its write SHALL appear 1 cycle later; a load's minimum latency is therefore 2 cycles.
REQ-009 Write-port priority SHALL be ALU accept first, then queue pop. At most one write SHALL occur per cycle.
REQ-010 Kill rule for an ALU accept to register D:
  - Every queued entry with dest D SHALL be marked killed.
  - Any load enqueued in the same cycle with dest D SHALL also be marked killed.
REQ-011 Popping a killed entry SHALL consume the cycle and keep reg_write_en=0.
REQ-012 reg_write_en SHALL be 0 in every cycle not produced by REQ-007 or REQ-008. In those cycles, dest and data SHALL hold their previous values.
REQ-013 busy_mask update rules:
  - Bit D SHALL be set on issue_valid with issue_dest=D.
  - Bit D SHALL be cleared on an ALU accept to D.
  - Bit D SHALL be cleared on the pop of a live entry to D.
  - If set and clear hit the same bit in the same cycle, set SHALL win.
REQ-014 Queue pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL range from 0 to FIFO_DEPTH. A simultaneous push and pop SHALL leave the count unchanged.
REQ-015 A load presented while the queue is full SHALL NOT be accepted or lost. The source holds mem_valid, mem_dest and mem_data until mem_ready=1.
REQ-016 When the queue is full, ALU acceptance SHALL stall until a pop makes the queue non-full. This guarantees forward progress for loads.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL reset:
  - Queue SHALL be emptied: count=0, pointers=0.
  - Kill flags SHALL be cleared.
  - busy_mask SHALL be 0.
  - reg_write_en, reg_write_dest and reg_write_data SHALL all be 0.
REQ-018 Reset asserted mid-operation SHALL discard every queued and in-flight result; no write SHALL be emitted in the cycle after reset.
REQ-019 With rst=1, alu_ready and mem_ready SHALL read 1 only after the first clock edge following reset deassertion.

Structure
REQ-020 The following shared constants SHALL live in package cpu_pkg: DATA_W, ADDR_W, NUM_REGS=8 and WB_FIFO_DEPTH=4.
REQ-021 The queue SHALL be the sub-module wb_fifo. It SHALL store {dest, data, killed}, expose count, and provide a per-entry dest-match kill input.
REQ-022 All outputs of reg_writeback SHALL be registered, except alu_ready and mem_ready, which SHALL decode the registered count.

Verification
REQ-023 ALU only: accept alu_dest=3, alu_data=16'h00A5 at cycle N -> reg_write_en=1, dest=3, data=16'h00A5 at N+1; en=0 at N+2.
REQ-024 Load with an idle ALU: issue_dest=5 at cycle N, so busy_mask[5]=1. Then mem_dest=5, mem_data=16'h1234 accepted at M -> write at M+2, and busy_mask[5]=0 at M+2.
REQ-025 Contention: ALU valid on 6 consecutive cycles while 4 loads arrive -> queue fills. Required responses:
  - alu_ready=0 for one cycle.
  - Loads drain in FIFO order.
  - No write is lost or duplicated.
  - mem_ready=0 while count=4.
REQ-026 Kill: load to register 2 queued (16'hBEEF), then ALU accepts dest=2, data=16'h0001 -> only the 16'h0001 write occurs, and the popped killed entry yields reg_write_en=0.
REQ-027 Reset mid-operation: 3 entries queued and busy_mask=8'h0E, then rst=1 for 1 cycle -> busy_mask=0, count=0, and no writes appear afterward.
